// File: rtl/hmmm_alu_pkg.sv
// hmmm_alu_pkg: shared op/state encodings and overflow constants for hmmm_seq_alu.
package hmmm_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_MOD = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Most negative two's-complement value of a w-bit word (zero-extended to 64 bits).
    function automatic logic [63:0] signed_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/hmmm_seq_divider.sv
// hmmm_seq_divider: restoring unsigned divider core, one quotient bit per cycle.
// The first bit is resolved on the start edge, so the remaining WIDTH-1 bits
// follow on consecutive cycles. done is high during the cycle whose closing
// edge produces the final bit; quotient/remainder are valid from the next cycle.
module hmmm_seq_divider #(
    parameter int  WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt;
    logic             run;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] quo,
                                                    input logic [WIDTH-1:0] dvs);
        logic [WIDTH:0]   trial;
        logic [WIDTH-1:0] rem_n;
        logic             fits;
        trial = {rem, quo[WIDTH-1]};
        fits  = (trial >= {1'b0, dvs});
        rem_n = fits ? WIDTH'(trial - {1'b0, dvs}) : trial[WIDTH-1:0];
        return {rem_n, quo[WIDTH-2:0], fits};
    endfunction

    assign done = run && (cnt == CNT_W'(1));

    // Load and resolve the top bit on start, then iterate until the down-counter expires.
    always_ff @(posedge clk) begin
        if (reset) begin
            run       <= 1'b0;
            cnt       <= '0;
            dvs_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            {remainder, quotient} <= div_step('0, dividend, divisor);
            dvs_q <= divisor;
            cnt   <= CNT_W'(WIDTH - 1);
            run   <= 1'b1;
        end else if (run) begin
            {remainder, quotient} <= div_step(remainder, quotient, dvs_q);
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hmmm_seq_alu.sv
// hmmm_seq_alu: multi-cycle signed ALU (add/sub/mul/div/mod) with start/busy/done.
// Optional build macro HMMM_ALU_EARLY_TERM_EN: multiply stops as soon as the
// remaining multiplier bits are zero; results and flags are unchanged.
//
// state | meaning
// IDLE  | waiting for start; add/sub/illegal complete here in one cycle
// CALC  | one shift-add (mul) or restoring (div/mod) iteration per cycle
// FIX   | sign correction, flag generation, done pulse
module hmmm_seq_alu
    import hmmm_alu_pkg::*;
#(
    parameter int  WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             err,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(signed_min(WIDTH));

    state_e             state;
    logic [2:0]         op_q;
    logic               neg_q;
    logic               a_neg_q;
    logic               b_zero_q;
    logic [2*WIDTH-1:0] mul_acc;
    logic [2*WIDTH-1:0] mul_add;
    logic [WIDTH-1:0]   mul_rem;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   as_res;
    logic               as_ovf;
    logic [2*WIDTH-1:0] prod;
    logic               mul_ovf;
    logic               mul_last;
    logic               mul_skip;
    logic [WIDTH-1:0]   quo_mag, rem_mag, quo_s, rem_s;
    logic               div_start, div_done;

    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    // Add/sub: overflow when the effective operand signs agree but the result sign differs.
    always_comb begin
        as_res = '0;
        as_ovf = 1'b0;
        if (op == OP_SUB) begin
            as_res = a - b;
            as_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (as_res[WIDTH-1] != a[WIDTH-1]);
        end else begin
            as_res = a + b;
            as_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (as_res[WIDTH-1] != a[WIDTH-1]);
        end
    end

    assign prod    = neg_q ? -mul_acc : mul_acc;
    assign mul_ovf = !((prod[2*WIDTH-1:WIDTH-1] == '0) || (prod[2*WIDTH-1:WIDTH-1] == '1));
    assign quo_s   = neg_q ? -quo_mag : quo_mag;
    assign rem_s   = a_neg_q ? -rem_mag : rem_mag;

`ifdef HMMM_ALU_EARLY_TERM_EN
    assign mul_skip = (b_mag[WIDTH-1:1] == '0);
    assign mul_last = (mul_rem[WIDTH-1:1] == '0);
`else
    assign mul_skip = 1'b0;
    assign mul_last = (cnt == CNT_W'(1));
`endif

    assign div_start = (state == IDLE) && start && ((op == OP_DIV) || (op == OP_MOD));

    hmmm_seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo_mag),
        .remainder (rem_mag),
        .done      (div_done)
    );

    // Control FSM with registered result, flags and handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            mul_acc  <= '0;
            mul_add  <= '0;
            mul_rem  <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        case (op)
                            OP_ADD, OP_SUB: begin
                                result <= as_res;
                                zero   <= (as_res == '0);
                                carry  <= as_ovf;
                                err    <= 1'b0;
                                done   <= 1'b1;
                            end
                            OP_MUL: begin
                                // Bit 0 of the multiplier is consumed on the accept edge.
                                neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
                                mul_acc <= b_mag[0] ? {{WIDTH{1'b0}}, a_mag} : '0;
                                mul_add <= {{(WIDTH-1){1'b0}}, a_mag, 1'b0};
                                mul_rem <= b_mag >> 1;
                                cnt     <= CNT_W'(WIDTH - 1);
                                busy    <= 1'b1;
                                state   <= mul_skip ? FIX : CALC;
                            end
                            OP_DIV, OP_MOD: begin
                                neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
                                a_neg_q  <= a[WIDTH-1];
                                b_zero_q <= (b == '0);
                                busy     <= 1'b1;
                                state    <= CALC;
                            end
                            default: begin
                                result <= '0;
                                zero   <= 1'b0;
                                carry  <= 1'b0;
                                err    <= 1'b1;
                                done   <= 1'b1;
                            end
                        endcase
                    end
                end
                CALC: begin
                    if (op_q == OP_MUL) begin
                        if (mul_rem[0]) begin
                            mul_acc <= mul_acc + mul_add;
                        end
                        mul_add <= mul_add << 1;
                        mul_rem <= mul_rem >> 1;
                        cnt     <= cnt - CNT_W'(1);
                        if (mul_last) begin
                            state <= FIX;
                        end
                    end else if (div_done) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                    if (op_q == OP_MUL) begin
                        result <= prod[WIDTH-1:0];
                        zero   <= (prod[WIDTH-1:0] == '0);
                        carry  <= mul_ovf;
                        err    <= 1'b0;
                    end else if (b_zero_q) begin
                        result <= '0;
                        zero   <= 1'b0;
                        carry  <= 1'b0;
                        err    <= 1'b1;
                    end else if (op_q == OP_DIV) begin
                        // Only MIN / -1 yields a positive quotient magnitude equal to MIN.
                        result <= quo_s;
                        zero   <= (quo_s == '0);
                        carry  <= !neg_q && (quo_mag == MIN_VAL);
                        err    <= 1'b0;
                    end else begin
                        result <= rem_s;
                        zero   <= (rem_s == '0);
                        carry  <= 1'b0;
                        err    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hmmm_seq_alu.sv
// tb_hmmm_seq_alu: self-checking bench for hmmm_seq_alu (WIDTH=16).
`timescale 1ns/1ps
module tb_hmmm_seq_alu;

    localparam int     W    = 16;
    localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (W - 1));

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] result;
    logic         zero, carry, err, busy, done;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         z;
        logic         c;
        logic         e;
    } vec_t;

    hmmm_seq_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .zero   (zero),
        .carry  (carry),
        .err    (err),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Reference: exact integer arithmetic, then truncate and range-check.
    function automatic logic [W+2:0] ref_alu(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint       sa, sb, full;
        logic [W-1:0] r;
        logic         c;
        sa   = longint'($signed(x));
        sb   = longint'($signed(y));
        full = 0;
        case (o)
            3'd0: full = sa + sb;
            3'd1: full = sa - sb;
            3'd2: full = sa * sb;
            3'd3: begin
                if (sb == 0) return {{W{1'b0}}, 3'b001};
                full = sa / sb;
            end
            3'd4: begin
                if (sb == 0) return {{W{1'b0}}, 3'b001};
                full = sa % sb;
            end
            default: return {{W{1'b0}}, 3'b001};
        endcase
        r = full[W-1:0];
        c = (full > SMAX) || (full < SMIN);
        return {r, (r == '0), c, 1'b0};
    endfunction

    // Expected cycles from the start cycle to the cycle where done is seen.
    function automatic int exp_lat(input logic [2:0] o, input logic [W-1:0] y);
        longint m;
        int     hb;
        m  = longint'($signed(y));
        hb = 0;
        if (o == 3'd2) begin
`ifdef HMMM_ALU_EARLY_TERM_EN
            if (m < 0) m = -m;
            for (int i = 0; i <= W; i++) if (m >= (longint'(1) << i)) hb = i;
            return hb + 2;
`else
            return W + 1;
`endif
        end
        if (o == 3'd3 || o == 3'd4) return W + 1;
        return 1;
    endfunction

    // Drive one request and wait (bounded) for done; optionally pulse start while busy.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit noise, output logic [W+2:0] obs, output int lat, output bit bok);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
        lat = 1;
        bok = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) bok = 1'b0;
            if (noise && lat == 3) begin
                start = 1'b1; op = 3'd0; a = 16'd1; b = 16'd1;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        if (busy !== 1'b0) bok = 1'b0;
        obs = {result, zero, carry, err};
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (result !== '0) begin errors++; $display("FAIL reset_result: got %h want 0000", result); end
        checks++;
        if ({zero, carry, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {zero, carry, err}); end
        checks++;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_handshake: got %b want 00", {busy, done}); end
        reset = 1'b0;
    endtask

    task automatic test_addsub();
        vec_t v[$];
        logic [W+2:0] obs;
        int lat;
        bit bok;
        v.push_back({3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0});
        v.push_back({3'd0, 16'h7FFF, 16'h0002, 16'h8001, 1'b0, 1'b1, 1'b0});
        v.push_back({3'd1, 16'h8001, 16'h0002, 16'h7FFF, 1'b0, 1'b1, 1'b0});
        v.push_back({3'd1, 16'hFFFD, 16'hFFFE, 16'hFFFF, 1'b0, 1'b0, 1'b0});
        foreach (v[i]) begin
            do_op(v[i].op, v[i].a, v[i].b, 1'b0, obs, lat, bok);
            checks++;
            if (obs !== {v[i].r, v[i].z, v[i].c, v[i].e}) begin
                errors++; $display("FAIL addsub[%0d]: got r=%h zce=%b want r=%h zce=%b", i, obs[W+2:3], obs[2:0], v[i].r, {v[i].z, v[i].c, v[i].e});
            end
            checks++;
            if (lat != 1 || !bok) begin errors++; $display("FAIL addsub_lat[%0d]: got lat=%0d busy_ok=%0d want lat=1 busy_ok=1", i, lat, bok); end
        end
    endtask

    task automatic test_mul();
        vec_t v[$];
        logic [W+2:0] obs;
        int lat;
        bit bok;
        v.push_back({3'd2, 16'h0003, 16'hFFFE, 16'hFFFA, 1'b0, 1'b0, 1'b0});
        v.push_back({3'd2, 16'd300,  16'd300,  16'h5F90, 1'b0, 1'b1, 1'b0});
        v.push_back({3'd2, 16'd100,  16'd3,    16'd300,  1'b0, 1'b0, 1'b0});
        v.push_back({3'd2, 16'd5,    16'd0,    16'd0,    1'b1, 1'b0, 1'b0});
        v.push_back({3'd2, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b0});
        v.push_back({3'd2, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0});
        foreach (v[i]) begin
            do_op(v[i].op, v[i].a, v[i].b, 1'b0, obs, lat, bok);
            checks++;
            if (obs !== {v[i].r, v[i].z, v[i].c, v[i].e}) begin
                errors++; $display("FAIL mul[%0d]: got r=%h zce=%b want r=%h zce=%b", i, obs[W+2:3], obs[2:0], v[i].r, {v[i].z, v[i].c, v[i].e});
            end
            checks++;
            if (lat != exp_lat(v[i].op, v[i].b) || !bok) begin
                errors++; $display("FAIL mul_lat[%0d]: got lat=%0d busy_ok=%0d want lat=%0d busy_ok=1", i, lat, bok, exp_lat(v[i].op, v[i].b));
            end
        end
    endtask

    task automatic test_divmod();
        vec_t v[$];
        logic [W+2:0] obs;
        int lat;
        bit bok;
        v.push_back({3'd3, 16'd15,   16'hFFFD, 16'hFFFB, 1'b0, 1'b0, 1'b0});
        v.push_back({3'd3, 16'hFFF1, 16'hFFFD, 16'd5,    1'b0, 1'b0, 1'b0});
        v.push_back({3'd4, 16'hFFF4, 16'd5,    16'hFFFE, 1'b0, 1'b0, 1'b0});
        v.push_back({3'd4, 16'd12,   16'hFFFB, 16'd2,    1'b0, 1'b0, 1'b0});
        v.push_back({3'd4, 16'd12,   16'd3,    16'd0,    1'b1, 1'b0, 1'b0});
        v.push_back({3'd3, 16'd1000, 16'd7,    16'd142,  1'b0, 1'b0, 1'b0});
        foreach (v[i]) begin
            do_op(v[i].op, v[i].a, v[i].b, 1'b0, obs, lat, bok);
            checks++;
            if (obs !== {v[i].r, v[i].z, v[i].c, v[i].e}) begin
                errors++; $display("FAIL divmod[%0d]: got r=%h zce=%b want r=%h zce=%b", i, obs[W+2:3], obs[2:0], v[i].r, {v[i].z, v[i].c, v[i].e});
            end
            checks++;
            if (lat != W + 1 || !bok) begin errors++; $display("FAIL divmod_lat[%0d]: got lat=%0d busy_ok=%0d want lat=%0d busy_ok=1", i, lat, bok, W + 1); end
        end
    endtask

    task automatic test_errors();
        vec_t v[$];
        logic [W+2:0] obs;
        int lat;
        bit bok;
        v.push_back({3'd3, 16'd7,    16'd0,    16'd0,    1'b0, 1'b0, 1'b1});
        v.push_back({3'd4, 16'd7,    16'd0,    16'd0,    1'b0, 1'b0, 1'b1});
        v.push_back({3'd3, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b0});
        v.push_back({3'd4, 16'h8000, 16'hFFFF, 16'd0,    1'b1, 1'b0, 1'b0});
        v.push_back({3'd6, 16'd4,    16'd4,    16'd0,    1'b0, 1'b0, 1'b1});
        v.push_back({3'd5, 16'd0,    16'd0,    16'd0,    1'b0, 1'b0, 1'b1});
        v.push_back({3'd7, 16'd9,    16'd2,    16'd0,    1'b0, 1'b0, 1'b1});
        foreach (v[i]) begin
            do_op(v[i].op, v[i].a, v[i].b, 1'b0, obs, lat, bok);
            checks++;
            if (obs !== {v[i].r, v[i].z, v[i].c, v[i].e}) begin
                errors++; $display("FAIL errcase[%0d]: got r=%h zce=%b want r=%h zce=%b", i, obs[W+2:3], obs[2:0], v[i].r, {v[i].z, v[i].c, v[i].e});
            end
            checks++;
            if (lat != exp_lat(v[i].op, v[i].b) || !bok) begin
                errors++; $display("FAIL errcase_lat[%0d]: got lat=%0d busy_ok=%0d want lat=%0d busy_ok=1", i, lat, bok, exp_lat(v[i].op, v[i].b));
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [W+2:0] obs;
        int lat, extra;
        bit bok;
        do_op(3'd2, 16'd3, 16'hFC18, 1'b1, obs, lat, bok);
        checks++;
        if (obs !== {16'hF448, 3'b000}) begin errors++; $display("FAIL busy_ignore_result: got %h want %h", obs, {16'hF448, 3'b000}); end
        checks++;
        if (lat != exp_lat(3'd2, 16'hFC18) || !bok) begin
            errors++; $display("FAIL busy_ignore_lat: got lat=%0d busy_ok=%0d want lat=%0d busy_ok=1", lat, bok, exp_lat(3'd2, 16'hFC18));
        end
        extra = 0;
        repeat (4) begin @(negedge clk); if (done === 1'b1) extra++; end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL busy_ignore_queued: got %0d extra done pulses want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        op = 3'd2; a = 16'd7; b = 16'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if ({done, busy, result} !== {1'b1, 1'b0, 16'd42}) begin
            errors++; $display("FAIL b2b_first: got done=%b busy=%b r=%h want done=1 busy=0 r=002a", done, busy, result);
        end
        op = 3'd0; a = 16'd5; b = 16'hFFF0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({done, result, carry} !== {1'b1, 16'hFFF5, 1'b0}) begin
            errors++; $display("FAIL b2b_second: got done=%b r=%h c=%b want done=1 r=fff5 c=0", done, result, carry);
        end
    endtask

    task automatic test_reset_midop();
        logic [W+2:0] obs;
        int lat, seen;
        bit bok;
        do_op(3'd0, 16'd2, 16'd3, 1'b0, obs, lat, bok);
        @(negedge clk);
        op = 3'd2; a = 16'd123; b = 16'd45; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({busy, result} !== {1'b1, 16'd5}) begin errors++; $display("FAIL midop_busy: got busy=%b r=%h want busy=1 r=0005", busy, result); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({result, zero, carry, err, busy, done} !== '0) begin
            errors++; $display("FAIL midop_reset: got r=%h zce=%b busy=%b done=%b want all 0", result, {zero, carry, err}, busy, done);
        end
        reset = 1'b0;
        seen = 0;
        repeat (25) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midop_no_done: got %0d busy/done cycles want 0", seen); end
    endtask

    task automatic test_random();
        logic [W+2:0] obs, expv;
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;
        int lat;
        bit bok;
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 4)) - W'(2) : W'($urandom);
            if ($urandom_range(0, 5) == 0) ra = 16'h8000;
            expv = ref_alu(ro, ra, rb);
            do_op(ro, ra, rb, 1'b0, obs, lat, bok);
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL rand[%0d] op=%0d a=%h b=%h: got r=%h zce=%b want r=%h zce=%b", i, ro, ra, rb, obs[W+2:3], obs[2:0], expv[W+2:3], expv[2:0]);
            end
            checks++;
            if (lat != exp_lat(ro, rb) || !bok) begin
                errors++; $display("FAIL rand_lat[%0d] op=%0d b=%h: got lat=%0d busy_ok=%0d want lat=%0d busy_ok=1", i, ro, rb, lat, bok, exp_lat(ro, rb));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        test_reset();
        test_addsub();
        test_mul();
        test_divmod();
        test_errors();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
